// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: memory request/response, redirect input and the
// prefetch-queue head handshake toward the decoder.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rdy;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               halted;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
    input  mem_rdy, mem_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
    output mem_rdy, mem_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a
// small prefetch queue, with redirect flush and halt-opcode stop.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OP   = 4'hF
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic                req, push, pop, flush;

  logic [INSTR_W-1:0]  q_instr [DEPTH];
  logic [ADDR_W-1:0]   q_pc    [DEPTH];

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    req          = (state == IDLE) && !bus.redirect_valid &&
                   (count < CNT_W'(DEPTH)) && !rst;

    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (bus.mem_rdy) begin
          push         = 1'b1;
          fetch_pc_nxt = next_pc(fetch_pc);
          state_nxt    = (bus.mem_data[INSTR_W-1 -: 4] == HLT_OP) ? HALT : IDLE;
        end
      end
      DROP: if (bus.mem_rdy) state_nxt = IDLE;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    // A redirect overrides any push/pop this cycle; a response still in
    // flight must be swallowed in DROP before fetching resumes.
    if (bus.redirect_valid) begin
      flush        = 1'b1;
      push         = 1'b0;
      fetch_pc_nxt = bus.redirect_pc;
      state_nxt    = ((state == WAIT || state == DROP) && !bus.mem_rdy) ? DROP : IDLE;
    end
  end

  assign pop = (count != '0) && bus.instr_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.mem_data;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != '0) && !rst;
  assign bus.halted      = (state == HALT) && !rst;
  assign bus.instr       = bus.instr_valid ? q_instr[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? q_pc[rd_ptr]    : '0;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: fetch address and PC width.
REQ-002 SHALL have parameter INSTR_W, default 16: instruction width; opcode = bits [INSTR_W-1:INSTR_W-4].
REQ-003 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of 2, at least 2.
REQ-004 SHALL have parameter PC_STEP, default 2: byte increment per instruction.
REQ-005 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-006 SHALL have parameter HLT_OP, default 4'hF: opcode that stops fetching.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port mem_req, output, 1: fetch request, accepted in the same cycle it is asserted.
REQ-010 SHALL have port mem_addr, output, ADDR_W: fetch address, valid while mem_req=1.
REQ-011 SHALL have port mem_rdy, input, 1: response valid, arriving one or more cycles after the request.
REQ-012 SHALL have port mem_data, input, INSTR_W: response instruction, valid while mem_rdy=1.
REQ-013 SHALL have port redirect_valid, input, 1: branch/PC redirect.
REQ-014 SHALL have port redirect_pc, input, ADDR_W: redirect target.
REQ-015 SHALL have port instr_valid, output, 1: queue head valid.
REQ-016 SHALL have port instr_ready, input, 1: consumer pops the queue head.
REQ-017 SHALL have port instr, output, INSTR_W: queue-head instruction.
REQ-018 SHALL have port instr_pc, output, ADDR_W: address of the queue-head instruction.
REQ-019 SHALL have port halted, output, 1: high while in HALT state.

Function
REQ-020 SHALL implement four states: IDLE, WAIT (one request outstanding), DROP (stale response pending), HALT.
REQ-021 SHALL hold at most one memory request outstanding at any time.
REQ-022 SHALL compute mem_req combinationally as state==IDLE and redirect_valid=0 and count<DEPTH; mem_addr SHALL equal the fetch PC register.
REQ-023 SHALL transition IDLE->WAIT on mem_req=1.
REQ-024 SHALL handle WAIT with mem_rdy=1 as follows: push {fetch PC, mem_data}; fetch PC += PC_STEP, wrapping modulo 2^ADDR_W; go to HALT if the opcode equals HLT_OP, otherwise go to IDLE.
REQ-025 SHALL handle DROP with mem_rdy=1 as follows: discard the data, push nothing, go to IDLE.
REQ-026 SHALL process redirect_valid=1 in any state, taking priority over push and pop in the same cycle, as follows: flush the queue (count=0); set fetch PC to redirect_pc; go to DROP from WAIT (unless mem_rdy=1 that same cycle, then IDLE), stay in DROP from DROP (unless mem_rdy=1, then IDLE), and go to IDLE from IDLE or HALT.
REQ-027 SHALL, in HALT, issue no requests; queued entries SHALL still drain; only redirect or reset leaves HALT.
REQ-028 SHALL make a pop occur when instr_valid=1 and instr_ready=1; instr_valid SHALL equal count!=0; instr and instr_pc SHALL come from registered queue storage (no combinational path from mem_data).
REQ-029 SHALL perform both operations when push and pop occur in the same cycle, leaving count unchanged; a push into a full queue is impossible by REQ-022.
REQ-030 SHALL ignore mem_rdy=1 in IDLE or HALT.
REQ-031 SHALL make latency minimum 2 cycles from mem_req to instr_valid with a 1-cycle memory: request in cycle N, response in cycle N+1, instr_valid in cycle N+2.
REQ-032 SHALL make throughput with a 1-cycle memory one instruction per 2 cycles; the next request issues in the cycle after the response.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set fetch PC=RESET_PC, count=0, state=IDLE, and read/write pointers=0, overriding every other input.
REQ-034 SHALL hold instr_valid=0, halted=0 and mem_req=0 throughout reset; instr and instr_pc SHALL read 0 after reset.
REQ-035 SHALL assert mem_req with mem_addr=RESET_PC in the first cycle after rst deasserts; a response to a pre-reset request SHALL be ignored per REQ-030.

Verification
REQ-036 SHALL cover sequential fill: 1-cycle memory returning 0x1111,0x2222,..., instr_ready=0 -> exactly 4 entries fetched at PCs 0,2,4,6; mem_req stays 0 while full; popping one issues a fetch at PC 8.
REQ-037 SHALL cover halt: 0xF000 fetched at PC 4 -> halted=1 next cycle; no further mem_req; the queue drains; redirect_pc=0x0020 -> halted=0 and the next mem_addr=0x0020.
REQ-038 SHALL cover redirect mid-flight: request at PC 0x0010, 3-cycle memory, redirect_pc=0x0040 one cycle later -> the response is dropped, the queue is empty, and the next mem_addr=0x0040.
REQ-039 SHALL cover simultaneous redirect, pop and response in WAIT -> the queue is empty, the response is discarded, state=IDLE, and fetch PC=redirect_pc.
REQ-040 SHALL cover PC wrap-around: ADDR_W=16, redirect_pc=0xFFFE -> the instruction is tagged 0xFFFE and the next mem_addr=0x0000.
REQ-041 SHALL cover reset mid-operation: rst=1 with 3 entries queued and a request outstanding -> instr_valid=0 next cycle; the first post-reset mem_addr=RESET_PC; the late stale mem_rdy is not enqueued.
